pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus of DATA_W bits with a valid/ready handshake, external stall (e.g. from DCache) and synchronous flush.
- Holds a 2-entry skid buffer so upstream ready is registered: no combinational ready path crosses the stage.
- Instantiated between any two pipeline stages; field packing/unpacking is done by the neighbouring stages.

Parameters:
- DATA_W, 64, payload width in bits (>=1).
- RST_VAL, {DATA_W{1'b0}}, value of out_data after reset (e.g. PC_RST in the PC field).
- FLUSH_CLR_DATA, 0, 1 = flush also loads RST_VAL into both entries; 0 = flush clears valids only.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hold stage: no beat accepted or released while high.
- flush  input  1  synchronous kill of all held beats and of any beat offered this cycle.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; registered-only dependency plus stall.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  downstream payload (main entry).
- occ  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry {m_v, m_d} drives out_valid/out_data. Skid entry {s_v, s_d} is internal.
- State is encoded by (m_v, s_v): EMPTY = (0,0), ONE = (1,0), TWO = (1,1). (0,1) is illegal and never reached.
- Reset (async, any time, including mid-transfer): m_v = s_v = 0, m_d = s_d = RST_VAL. Outputs: out_valid = 0, out_data = RST_VAL, occ = 0, in_ready = 0 while rst is high, 1 after release.
- in_ready = !s_v && !stall. It depends on no combinational input other than stall.
- acc = in_valid && in_ready && !flush. rel = out_valid && out_ready && !stall.
- Priority per edge: rst > flush > stall > normal.
- flush = 1: next state EMPTY. The incoming beat is dropped even if in_ready = 1. Data is held, or set to RST_VAL when FLUSH_CLR_DATA = 1. Flush overrides stall.
- stall = 1 (no flush): all registers hold. out_valid/out_data are unchanged and visible, but the downstream handshake is ignored.
- Normal transitions:
  - EMPTY, acc: load main, go to ONE.
  - ONE, acc && !rel: load skid, go to TWO.
  - ONE, acc && rel: load main, stay ONE.
  - ONE, !acc && rel: go to EMPTY.
  - TWO, rel: main <= skid, go to ONE (acc is impossible because in_ready = 0).
  - Otherwise: hold.
- Latency: 1 cycle from acc to out_valid when EMPTY. Sustained throughput 1 beat/cycle with out_ready high.
- Order is strictly FIFO. No beat is duplicated or lost except by flush.
- Backpressure: out_ready low for 1 cycle with in_valid high fills skid, and in_ready drops the next cycle.
- occ = m_v + s_v.
- Payload never passes combinationally from in_data to out_data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds 32-bit output ports stall_cnt and bubble_cnt, reset to 0:
  - stall_cnt increments each cycle stall = 1 and out_valid = 1.
  - bubble_cnt increments each cycle out_valid = 0 and out_ready = 1 with stall = 0.
  - Both saturate at 32'hFFFF_FFFF and clear on flush.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RST_VAL = 64'h1C00_0000_0000_0000, hold rst 3 cycles -> out_data = RST_VAL, out_valid = 0, occ = 0, in_ready = 0 during reset and 1 one cycle after release.
- Stream 8 beats 1..8, out_ready = 1 -> out_data 1..8 on consecutive cycles, first beat 1 cycle after acceptance, occ never exceeds 1.
- Beats A, B, C, out_ready = 0 for 2 cycles -> occ reaches 2, in_ready = 0 while C waits; then out_ready = 1 -> order A, B, C with no loss.
- Stage holding TWO beats, stall = 1 for 4 cycles with out_ready = 1 -> out_data constant, occ = 2 throughout; after stall drops, both beats drain in order.
- TWO beats held, flush = 1 together with in_valid = 1 and stall = 1 -> next cycle occ = 0, out_valid = 0, offered beat absent; with FLUSH_CLR_DATA = 1, out_data = RST_VAL.
- PIPE_STAGE_PERF_EN build: 5 stall cycles with a valid beat, then 3 idle cycles with out_ready = 1 -> stall_cnt = 5, bubble_cnt = 3; a flush returns both to 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic inter-stage pipeline register with a valid/ready handshake, an
//   external stall, a synchronous flush and a 2-entry skid buffer. in_ready is
//   driven from registered state plus stall only, so no combinational ready
//   path crosses the stage. The payload is opaque: neighbouring stages pack
//   and unpack their own fields.
//
// Parameters
//   DATA_W          payload width in bits (>= 1)
//   RST_VAL         out_data value after reset
//   FLUSH_CLR_DATA  1: flush also loads RST_VAL into both entries
//                   0: flush clears the valid bits only
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   stall      in   hold everything; no beat accepted or released
//   flush      in   kill all held beats and any beat offered this cycle
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat
//   in_data    in   upstream payload [DATA_W]
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream accepts
//   out_data   out  downstream payload [DATA_W] (main entry)
//   occ        out  entries held: 0, 1 or 2
//
// Optional build macro: PIPE_STAGE_PERF_EN
//   Adds stall_cnt[31:0] (cycles stalled while holding a valid beat) and
//   bubble_cnt[31:0] (cycles downstream was ready but got nothing). Both
//   saturate and clear on flush.
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                DATA_W         = 64,
  parameter logic [DATA_W-1:0] RST_VAL        = {DATA_W{1'b0}},
  parameter int                FLUSH_CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // Occupancy is encoded directly by the two valid bits {m_v, s_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  logic              m_v;
  logic              s_v;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] s_d;
  logic              rdy_q;   // low in reset, set on the first edge after release
  logic              acc;
  logic              rel;
  state_e            state;

  assign state     = state_e'({m_v, s_v});
  assign in_ready  = rdy_q && !s_v && !stall;
  assign acc       = in_valid && in_ready && !flush;
  assign rel       = m_v && out_ready && !stall;

  assign out_valid = m_v;
  assign out_data  = m_d;
  assign occ       = {1'b0, m_v} + {1'b0, s_v};

  // NOTE: the payload entries are reset along with the valids so out_data
  // shows RST_VAL (e.g. a PC reset vector) straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      m_v   <= 1'b0;
      s_v   <= 1'b0;
      m_d   <= RST_VAL;
      s_d   <= RST_VAL;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        // Flush wins over stall and drops the beat offered this cycle.
        m_v <= 1'b0;
        s_v <= 1'b0;
        if (FLUSH_CLR_DATA != 0) begin
          m_d <= RST_VAL;
          s_d <= RST_VAL;
        end
      end else if (!stall) begin
        unique case (state)
          EMPTY: begin
            if (acc) begin
              m_v <= 1'b1;
              m_d <= in_data;
            end
          end
          ONE: begin
            if (acc && !rel) begin
              s_v <= 1'b1;
              s_d <= in_data;
            end else if (acc && rel) begin
              m_d <= in_data;
            end else if (rel) begin
              m_v <= 1'b0;
            end
          end
          TWO: begin
            // in_ready is low here, so only a release can happen.
            if (rel) begin
              m_d <= s_d;
              s_v <= 1'b0;
            end
          end
          default: begin
            // (0,1) is unreachable; fall back to EMPTY if it ever appears.
            m_v <= 1'b0;
            s_v <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else if (flush) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (stall && m_v && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (!stall && !m_v && out_ready && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Self-checking bench for pipe_stage_skid. Two instances share all inputs:
//   dut clears data on flush, dut_hold keeps it. A reference model treats the
//   stage as a 2-deep FIFO (queue) with registered ready and tracks the value
//   the head position shows when empty.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int        W  = 64;
  localparam logic [W-1:0] RV = 64'h1C00_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst, stall, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;
  logic         h_in_ready, h_out_valid;
  logic [W-1:0] h_out_data;
  logic [1:0]   h_occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt, bubble_cnt, h_stall_cnt, h_bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .RST_VAL(RV), .FLUSH_CLR_DATA(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_skid #(.DATA_W(W), .RST_VAL(RV), .FLUSH_CLR_DATA(0)) dut_hold (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
    .occ(h_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(h_stall_cnt), .bubble_cnt(h_bubble_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [W-1:0] q[$];
  bit           started;
  logic [W-1:0] exp_data;
  logic [W-1:0] hold_exp;

  // Advance one clock, apply the FIFO rules to the model using the inputs
  // seen at the edge, then step 1 time unit past the edge for sampling.
  task automatic tick();
    bit rdy;
    @(posedge clk);
    if (!rst) begin
      rdy = started && (q.size() < 2) && !stall;
      if (flush) begin
        q.delete();
        exp_data = RV;
      end else if (!stall) begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(in_data);
      end
      started = 1'b1;
      if (q.size() > 0) begin
        exp_data = q[0];
        hold_exp = q[0];
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    q.delete(); started = 1'b0; exp_data = RV; hold_exp = RV;
    #1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    q.delete(); started = 1'b0; exp_data = RV; hold_exp = RV;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== RV || occ !== 2'd0 || in_ready !== 1'b0)
        $display("FAIL reset_hold[%0d] got v=%b d=%h occ=%0d rdy=%b exp v=0 d=%h occ=0 rdy=0",
                 i, out_valid, out_data, occ, in_ready, RV);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== RV)
      $display("FAIL reset_release got rdy=%b v=%b d=%h exp rdy=1 v=0 d=%h",
               in_ready, out_valid, out_data, RV);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset(1); tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = W'(k);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || occ !== 2'd1 || in_ready !== 1'b1)
        $display("FAIL stream[%0d] got v=%b d=%0d occ=%0d rdy=%b exp v=1 d=%0d occ=1 rdy=1",
                 k, out_valid, out_data, occ, in_ready, k);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occ);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    logic [W-1:0] got[$];
    bit acc_now;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    do_reset(1); tick();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = a; tick();
    in_data = b; tick();
    n_checks++;
    if (occ !== 2'd2 || in_ready !== 1'b0)
      $display("FAIL bp_fill got occ=%0d rdy=%b exp occ=2 rdy=0", occ, in_ready);
    else n_pass++;
    in_data = c; tick();
    n_checks++;
    if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== a)
      $display("FAIL bp_wait got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=%h",
               occ, in_ready, out_data, a);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_ready) got.push_back(out_data);
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 3)
      $display("FAIL bp_count got %0d beats exp 3", got.size());
    else if (got[0] !== a || got[1] !== b || got[2] !== c)
      $display("FAIL bp_order got %h %h %h exp %h %h %h", got[0], got[1], got[2], a, b, c);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [W-1:0] x, y;
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    do_reset(1); tick();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = x; tick();
    in_data = y; tick();
    stall = 1'b1; out_ready = 1'b1; in_data = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== x || occ !== 2'd2 || in_ready !== 1'b0)
        $display("FAIL stall_hold[%0d] got v=%b d=%h occ=%0d rdy=%b exp v=1 d=%h occ=2 rdy=0",
                 i, out_valid, out_data, occ, in_ready, x);
      else n_pass++;
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== y || occ !== 2'd1)
      $display("FAIL stall_drain1 got v=%b d=%h occ=%0d exp v=1 d=%h occ=1",
               out_valid, out_data, occ, y);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL stall_drain2 got v=%b occ=%0d exp v=0 occ=0", out_valid, occ);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [W-1:0] x, y;
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    do_reset(1); tick();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = x; tick();
    in_data = y; tick();
    flush = 1'b1; stall = 1'b1; in_data = {$urandom, $urandom};
    tick();
    n_checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== RV)
      $display("FAIL flush_clr got occ=%0d v=%b d=%h exp occ=0 v=0 d=%h",
               occ, out_valid, out_data, RV);
    else n_pass++;
    n_checks++;
    if (h_occ !== 2'd0 || h_out_valid !== 1'b0 || h_out_data !== x)
      $display("FAIL flush_hold got occ=%0d v=%b d=%h exp occ=0 v=0 d=%h",
               h_occ, h_out_valid, h_out_data, x);
    else n_pass++;
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL flush_dropped got v=%b occ=%0d exp v=0 occ=0", out_valid, occ);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(1); tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== RV || in_ready !== 1'b0)
      $display("FAIL async_reset got v=%b occ=%0d d=%h rdy=%b exp v=0 occ=0 d=%h rdy=0",
               out_valid, occ, out_data, in_ready, RV);
    else n_pass++;
    do_reset(2);
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset(1); tick();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      exp_rdy = started && (q.size() < 2) && !stall;
      n_checks++;
      if (out_valid !== (q.size() > 0) || occ !== 2'(q.size()) || in_ready !== exp_rdy ||
          out_data !== exp_data || h_out_data !== hold_exp)
        $display("FAIL random[%0d] got v=%b occ=%0d rdy=%b d=%h hd=%h exp v=%b occ=%0d rdy=%b d=%h hd=%h",
                 i, out_valid, occ, in_ready, out_data, h_out_data,
                 (q.size() > 0), q.size(), exp_rdy, exp_data, hold_exp);
      else n_pass++;
    end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    do_reset(1); tick();
    in_valid = 1'b1; in_data = 64'd5; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd0)
      $display("FAIL perf_stall got s=%0d b=%0d exp s=5 b=0", stall_cnt, bubble_cnt);
    else n_pass++;
    stall = 1'b0; out_ready = 1'b1;
    tick();
    repeat (3) tick();
    n_checks++;
    if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3)
      $display("FAIL perf_bubble got s=%0d b=%0d exp s=5 b=3", stall_cnt, bubble_cnt);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0)
      $display("FAIL perf_flush got s=%0d b=%0d exp s=0 b=0", stall_cnt, bubble_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
